// File: rtl/corruption_sweep_ctrl_pkg.sv
// ============================================================================
//  Module      : corruption_sweep_ctrl_pkg
//  Description : Shared FSM encodings and Hamming(7,4) position tables for the
//                corruption sweep controller and its decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package corruption_sweep_ctrl_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_apply = 3'd2;
    localparam logic [2:0] c_st_check = 3'd3;
    localparam logic [2:0] c_st_next  = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    // Word positions covered by each syndrome bit, vectors indexed [7:1]
    localparam logic [7:1] c_syn0_mask = 7'b1010101;  // positions 1,3,5,7
    localparam logic [7:1] c_syn1_mask = 7'b1100110;  // positions 2,3,6,7
    localparam logic [7:1] c_syn2_mask = 7'b1111000;  // positions 4,5,6,7

    // Code-word position of data bit i (data bits 1..4 -> positions 3,5,6,7)
    localparam logic [4:1][2:0] c_data_pos = {3'd7, 3'd6, 3'd5, 3'd3};

endpackage

`default_nettype wire

// File: rtl/hamming74_decode.sv
// ============================================================================
//  Module      : hamming74_decode
//  Description : Combinational Hamming(7,4) syndrome computation and
//                single-bit correction with data extraction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming74_decode
    import corruption_sweep_ctrl_pkg::*;
(
    input  logic [7:1] i_word,
    output logic [2:0] o_syndrome,
    output logic [4:1] o_data
);

    logic [7:1] w_fixed;

    assign o_syndrome = {^(i_word & c_syn2_mask),
                         ^(i_word & c_syn1_mask),
                         ^(i_word & c_syn0_mask)};

    // A non-zero syndrome names the position of the flipped bit
    always_comb begin
        w_fixed = i_word;
        if (o_syndrome != 3'd0) begin
            w_fixed[o_syndrome] = ~i_word[o_syndrome];
        end
        o_data = '0;
        for (int i = 1; i <= 4; i++) begin
            o_data[i] = w_fixed[c_data_pos[i]];
        end
    end

endmodule

`default_nettype wire

// File: rtl/corruption_sweep_ctrl.sv
// ============================================================================
//  Module      : corruption_sweep_ctrl
//  Description : Drives a Hamming(7,4) code word and corruption index to the
//                corrupter, decodes the returned word and scores each check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module corruption_sweep_ctrl
    import corruption_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int LAST_INDEX    = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       sweep_mode,
    input  logic [2:0] index_in,
    input  logic [4:1] data_in,
    output logic [7:1] code_word,
    output logic [2:0] corrupt_index,
    input  logic [7:1] corrupted_word,
    output logic [2:0] syndrome,
    output logic [4:1] corrected_data,
    output logic [3:0] pass_count,
    output logic [3:0] fail_count,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] c_settle_init = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] c_last_index  = 3'(LAST_INDEX);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [4:1] r_data;
    logic [2:0] r_index;
    logic       r_sweep;
    logic [3:0] r_settle_cnt;
    logic [7:1] r_code_word;
    logic [2:0] r_corrupt_index;
    logic [2:0] r_syndrome;
    logic [4:1] r_corrected;
    logic [3:0] r_pass;
    logic [3:0] r_fail;
    logic       r_done;
    logic       w_busy;
    logic       w_accept;
    logic       w_pass;
    logic [7:1] w_data_word;
    logic [7:1] w_encoded;
    logic [2:0] w_dec_syndrome;
    logic [4:1] w_dec_data;

    // Encoder: place data bits, then fill parity positions 1, 2 and 4
    always_comb begin
        w_data_word = '0;
        for (int i = 1; i <= 4; i++) begin
            w_data_word[c_data_pos[i]] = r_data[i];
        end
    end

    assign w_encoded = w_data_word | {3'b000,
                                      ^(w_data_word & c_syn2_mask),
                                      1'b0,
                                      ^(w_data_word & c_syn1_mask),
                                      ^(w_data_word & c_syn0_mask)};

    hamming74_decode u_decode (
        .i_word     (corrupted_word),
        .o_syndrome (w_dec_syndrome),
        .o_data     (w_dec_data)
    );

    assign w_accept = start && !abort &&
                      ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_pass   = (w_dec_syndrome == r_corrupt_index) && (w_dec_data == r_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle,
                c_st_done:  if (start) w_next_state = c_st_load;
                c_st_load:  w_next_state = c_st_apply;
                c_st_apply: if (r_settle_cnt == 4'd0) w_next_state = c_st_check;
                c_st_check: w_next_state = c_st_next;
                c_st_next: begin
                    if (!r_sweep || (r_corrupt_index == c_last_index)) begin
                        w_next_state = c_st_done;
                    end else begin
                        w_next_state = c_st_apply;
                    end
                end
                default:    w_next_state = c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            c_st_load, c_st_apply, c_st_check, c_st_next: w_busy = 1'b1;
            default:                                      w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data          <= '0;
            r_index         <= '0;
            r_sweep         <= 1'b0;
            r_settle_cnt    <= '0;
            r_code_word     <= '0;
            r_corrupt_index <= '0;
            r_syndrome      <= '0;
            r_corrected     <= '0;
            r_pass          <= '0;
            r_fail          <= '0;
            r_done          <= 1'b0;
        end else begin
            r_done <= (r_state == c_st_next) && (w_next_state == c_st_done);

            if (w_accept) begin
                r_data  <= data_in;
                r_index <= index_in;
                r_sweep <= sweep_mode;
                r_pass  <= '0;
                r_fail  <= '0;
            end

            if ((w_next_state == c_st_apply) && (r_state != c_st_apply)) begin
                r_settle_cnt <= c_settle_init;
            end else if ((r_state == c_st_apply) && (r_settle_cnt != 4'd0)) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end

            // Abort parks the corrupter on index 0 but leaves results intact
            if (abort) begin
                r_corrupt_index <= '0;
            end else begin
                case (r_state)
                    c_st_load: begin
                        r_code_word     <= w_encoded;
                        r_corrupt_index <= r_sweep ? 3'd0 : r_index;
                    end
                    c_st_check: begin
                        r_syndrome  <= w_dec_syndrome;
                        r_corrected <= w_dec_data;
                        if (w_pass) begin
                            r_pass <= (r_pass == 4'hF) ? r_pass : r_pass + 4'd1;
                        end else begin
                            r_fail <= (r_fail == 4'hF) ? r_fail : r_fail + 4'd1;
                        end
                    end
                    c_st_next: begin
                        if (w_next_state == c_st_apply) begin
                            r_corrupt_index <= r_corrupt_index + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign code_word      = r_code_word;
    assign corrupt_index  = r_corrupt_index;
    assign syndrome       = r_syndrome;
    assign corrected_data = r_corrected;
    assign pass_count     = r_pass;
    assign fail_count     = r_fail;
    assign busy           = w_busy;
    assign done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_corruption_sweep_ctrl.sv
// ============================================================================
//  Module      : tb_corruption_sweep_ctrl
//  Description : Self-checking bench with a behavioural corrupter and a
//                position-XOR Hamming reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_corruption_sweep_ctrl;

    localparam int SETTLE = 1;
    localparam int LAST   = 7;

    logic       clk = 1'b0;
    logic       reset_n, start, abort, sweep_mode, fault;
    logic [2:0] index_in;
    logic [4:1] data_in;
    logic [7:1] code_word, corrupted_word;
    logic [2:0] corrupt_index, syndrome;
    logic [4:1] corrected_data;
    logic [3:0] pass_count, fail_count;
    logic       busy, done;

    int         total = 0;
    int         bad   = 0;
    int         cyc;
    logic [2:0] m_syn;
    logic [4:1] m_corr;

    always #5 clk = ~clk;

    corruption_sweep_ctrl #(.SETTLE_CYCLES(SETTLE), .LAST_INDEX(LAST)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .sweep_mode     (sweep_mode),
        .index_in       (index_in),
        .data_in        (data_in),
        .code_word      (code_word),
        .corrupt_index  (corrupt_index),
        .corrupted_word (corrupted_word),
        .syndrome       (syndrome),
        .corrected_data (corrected_data),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .busy           (busy),
        .done           (done)
    );

    function automatic logic [7:1] ref_encode(input logic [4:1] d);
        logic [7:1] c;
        c    = '0;
        c[3] = d[1]; c[5] = d[2]; c[6] = d[3]; c[7] = d[4];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        return c;
    endfunction

    // Corrupter: flip bit k; the fault variant flips bits 1 and 2 at index 3
    function automatic logic [7:1] ref_flip(input logic [2:0] k, input logic f);
        logic [7:1] m;
        m = '0;
        if (f && (k == 3'd3)) m = 7'b0000011;
        else if (k != 3'd0) m[k] = 1'b1;
        return m;
    endfunction

    // Syndrome as the XOR of the positions of all set bits
    function automatic logic [2:0] ref_syn(input logic [7:1] w);
        logic [2:0] s;
        s = '0;
        for (int i = 1; i <= 7; i++) if (w[i]) s = s ^ 3'(i);
        return s;
    endfunction

    function automatic logic [4:1] ref_data(input logic [7:1] w, input logic [2:0] s);
        logic [7:1] x;
        x = w;
        if (s != 3'd0) x[s] = ~x[s];
        return {x[7], x[6], x[5], x[3]};
    endfunction

    always_comb corrupted_word = code_word ^ ref_flip(corrupt_index, fault);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic sw, input logic [2:0] idx, input logic [4:1] d,
                             input logic f);
        fault      = f;
        sweep_mode = sw;
        index_in   = idx;
        data_in    = d;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        sweep_mode = 1'($urandom);
        index_in   = 3'($urandom);
        data_in    = 4'($urandom);
        cyc        = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_run(input logic sw, input logic [2:0] idx, input logic [4:1] d,
                              input logic f, input string tag);
        int p, fl, lo, hi;
        logic [7:1] r;
        logic [2:0] s;
        logic [4:1] dd;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc),
            sw ? 32'(2 + (LAST + 1) * (2 + SETTLE)) : 32'(4 + SETTLE));
        p  = 0;
        fl = 0;
        lo = sw ? 0 : int'(idx);
        hi = sw ? LAST : int'(idx);
        for (int k = lo; k <= hi; k++) begin
            r  = ref_encode(d) ^ ref_flip(3'(k), f);
            s  = ref_syn(r);
            dd = ref_data(r, s);
            if (s == 3'(k) && dd == d) p++;
            else fl++;
            m_syn  = s;
            m_corr = dd;
        end
        chk({tag, "_pass"},      32'(pass_count),     32'(p));
        chk({tag, "_fail"},      32'(fail_count),     32'(fl));
        chk({tag, "_syndrome"},  32'(syndrome),       32'(m_syn));
        chk({tag, "_corrected"}, 32'(corrected_data), 32'(m_corr));
        chk({tag, "_code_word"}, 32'(code_word),      32'(ref_encode(d)));
        chk({tag, "_index"},     32'(corrupt_index),  32'(hi));
        chk({tag, "_busy_done"}, 32'(busy),           32'd0);
    endtask

    initial begin
        int seen;
        logic       rsw, rf;
        logic [2:0] ridx;
        logic [4:1] rd;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; sweep_mode = 1'b0;
        index_in = '0; data_in = '0; fault = 1'b0;
        m_syn = '0; m_corr = '0;
        repeat (2) @(negedge clk);
        chk("rst_code_word", 32'(code_word), 32'd0);
        chk("rst_index",     32'(corrupt_index), 32'd0);
        chk("rst_syndrome",  32'(syndrome), 32'd0);
        chk("rst_corrected", 32'(corrected_data), 32'd0);
        chk("rst_counts",    32'({pass_count, fail_count}), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy_done", 32'({busy, done}), 32'd0);

        // Single, index 0, data 1011
        start_run(1'b0, 3'd0, 4'b1011, 1'b0);
        finish_run(1'b0, 3'd0, 4'b1011, 1'b0, "single_idx0");
        chk("idx0_code_literal", 32'(code_word), 32'(7'b1010101));
        chk("idx0_corr_literal", 32'(corrected_data), 32'(4'b1011));
        @(negedge clk);
        chk("done_one_cycle", 32'({busy, done}), 32'd0);

        // Single, index 5
        start_run(1'b0, 3'd5, 4'b1011, 1'b0);
        finish_run(1'b0, 3'd5, 4'b1011, 1'b0, "single_idx5");
        chk("idx5_corrupted_literal", 32'(corrupted_word), 32'(7'b1000101));
        chk("idx5_syndrome_literal",  32'(syndrome), 32'd5);

        // Sweep, then a faulty sweep started on the done cycle
        @(negedge clk);
        start_run(1'b1, 3'd0, 4'b0110, 1'b0);
        finish_run(1'b1, 3'd0, 4'b0110, 1'b0, "sweep_clean");
        chk("sweep_pass_literal", 32'(pass_count), 32'd8);
        chk("sweep_cycle_literal", 32'(cyc), 32'd26);
        start_run(1'b1, 3'd0, 4'b0110, 1'b1);
        finish_run(1'b1, 3'd0, 4'b0110, 1'b1, "sweep_fault");
        chk("fault_counts_literal", 32'({pass_count, fail_count}), 32'h71);

        // Start re-pulsed during APPLY is ignored
        @(negedge clk);
        start_run(1'b0, 3'd2, 4'b1001, 1'b0);
        @(negedge clk);
        start = 1'b1; data_in = 4'b0110; index_in = 3'd6; sweep_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 3;
        finish_run(1'b0, 3'd2, 4'b1001, 1'b0, "repulse");

        // Abort during APPLY
        @(negedge clk);
        start_run(1'b0, 3'd4, 4'b1110, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",      32'(busy), 32'd0);
        chk("abort_index",     32'(corrupt_index), 32'd0);
        chk("abort_counts",    32'({pass_count, fail_count}), 32'd0);
        chk("abort_code_word", 32'(code_word), 32'(ref_encode(4'b1110)));
        chk("abort_syndrome",  32'(syndrome), 32'(m_syn));
        chk("abort_corrected", 32'(corrected_data), 32'(m_corr));
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Abort beats start on the same cycle
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_over_start", 32'(busy), 32'd0);
        @(negedge clk);
        chk("abort_over_start_hold", 32'({busy, done}), 32'd0);

        // Randomized runs, each started on the previous done cycle
        for (int t = 0; t < 12; t++) begin
            rsw  = 1'($urandom);
            ridx = 3'($urandom);
            rd   = 4'($urandom);
            rf   = 1'($urandom);
            start_run(rsw, ridx, rd, rf);
            finish_run(rsw, ridx, rd, rf, "random");
        end

        // Reset in the middle of a sweep
        @(negedge clk);
        start_run(1'b1, 3'd0, 4'($urandom), 1'b0);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_code_word", 32'(code_word), 32'd0);
        chk("midrst_index",     32'(corrupt_index), 32'd0);
        chk("midrst_results",   32'({syndrome, corrected_data}), 32'd0);
        chk("midrst_counts",    32'({pass_count, fail_count}), 32'd0);
        chk("midrst_busy_done", 32'({busy, done}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
